// File: rtl/atomic_sequencer_if.sv
// Pipeline-side and data-memory-side signals of the RV32A atomic sequencer.
// master: pipeline/memory environment; slave: the sequencer itself.
// Pure wiring bundle, no logic or latency of its own.
interface atomic_sequencer_if #(
    parameter int XLEN = 32
);
    logic            amo_valid;
    logic [4:0]      amo_funct5;
    logic [XLEN-1:0] amo_addr;
    logic [XLEN-1:0] amo_rs2;
    logic            interrupt;
    logic            store_snoop_valid;
    logic [XLEN-1:0] store_snoop_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            atomic_unit_stall;
    logic            atomic_unit_hazard;
    logic [XLEN-1:0] amo_result;
    logic            reservation_valid;

    modport master (
        output amo_valid, amo_funct5, amo_addr, amo_rs2, interrupt,
               store_snoop_valid, store_snoop_addr, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, atomic_unit_stall,
               atomic_unit_hazard, amo_result, reservation_valid
    );

    modport slave (
        input  amo_valid, amo_funct5, amo_addr, amo_rs2, interrupt,
               store_snoop_valid, store_snoop_addr, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, atomic_unit_stall,
               atomic_unit_hazard, amo_result, reservation_valid
    );
endinterface

// File: rtl/atomic_sequencer.sv
// RV32A sequencer (LR/SC/AMO) at MEM: owns the reservation, runs read-modify-write on data memory.
// Latency: LR 3, SC fail 2, SC ok 3, AMO 4 cycles start..DONE; +1 per cycle mem_ack is withheld.
// Backpressure: holds mem_req/addr/wdata steady until mem_ack; freezes the pipeline via atomic_unit_stall.
module atomic_sequencer #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    atomic_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    logic [1:0]      state_q, state_d;
    logic [4:0]      funct5_q, funct5_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] old_q, old_d;
    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:2] res_addr_q, res_addr_d;
    logic            sc_fail_q, sc_fail_d;

    logic            start;
    logic            in_is_sc;
    logic            q_is_lr;
    logic            q_is_sc;
    logic            res_hit;
    logic            snoop_hit;
    logic            res_clr;
    logic            lr_set;
    logic [XLEN-1:0] amo_wdata;

    // Word-granular compares; the low two address bits never affect a reservation.
    assign start     = (state_q == S_IDLE) && bus.amo_valid && !bus.interrupt;
    assign in_is_sc  = (bus.amo_funct5 == F_SC);
    assign q_is_lr   = (funct5_q == F_LR);
    assign q_is_sc   = (funct5_q == F_SC);
    assign res_hit   = res_valid_q && (bus.amo_addr[XLEN-1:2] == res_addr_q);
    assign snoop_hit = bus.store_snoop_valid &&
                       ((bus.store_snoop_addr & ~{{(XLEN-2){1'b0}}, 2'b11}) == {res_addr_q, 2'b00});

    // An LR completing its read claims the reservation even if a clear event lands on the same edge.
    assign lr_set  = (state_q == S_READ) && bus.mem_ack && q_is_lr;
    assign res_clr = bus.interrupt || snoop_hit ||
                     ((state_q == S_DONE) && q_is_sc) ||
                     ((state_q == S_WRITE) && bus.mem_ack && !q_is_sc &&
                      (addr_q[XLEN-1:2] == res_addr_q));

    // Read-modify-write operator applied to the captured old value; unknown codes behave as SWAP.
    always_comb begin
        amo_wdata = rs2_q;
        case (funct5_q)
            F_ADD:   amo_wdata = old_q + rs2_q;
            F_XOR:   amo_wdata = old_q ^ rs2_q;
            F_AND:   amo_wdata = old_q & rs2_q;
            F_OR:    amo_wdata = old_q | rs2_q;
            F_MIN:   amo_wdata = ($signed(old_q) < $signed(rs2_q)) ? old_q : rs2_q;
            F_MAX:   amo_wdata = ($signed(old_q) > $signed(rs2_q)) ? old_q : rs2_q;
            F_MINU:  amo_wdata = (old_q < rs2_q) ? old_q : rs2_q;
            F_MAXU:  amo_wdata = (old_q > rs2_q) ? old_q : rs2_q;
            default: amo_wdata = rs2_q;
        endcase
    end

    // Sequencing: latch the instruction at start, then walk READ/WRITE as the memory acks.
    always_comb begin
        state_d   = state_q;
        funct5_d  = funct5_q;
        addr_d    = addr_q;
        rs2_d     = rs2_q;
        old_d     = old_q;
        sc_fail_d = sc_fail_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    funct5_d  = bus.amo_funct5;
                    addr_d    = bus.amo_addr;
                    rs2_d     = bus.amo_rs2;
                    sc_fail_d = 1'b0;
                    if (in_is_sc) begin
                        if (res_hit) begin
                            state_d = S_WRITE;
                        end else begin
                            state_d   = S_DONE;
                            sc_fail_d = 1'b1;
                        end
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (bus.mem_ack) begin
                    old_d   = bus.mem_rdata;
                    state_d = q_is_lr ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.mem_ack) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reservation bookkeeping: set wins over a coincident clear.
    always_comb begin
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        if (lr_set) begin
            res_valid_d = 1'b1;
            res_addr_d  = addr_q[XLEN-1:2];
        end else if (res_clr) begin
            res_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset drops any in-flight access.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            funct5_q    <= '0;
            addr_q      <= '0;
            rs2_q       <= '0;
            old_q       <= '0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            sc_fail_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct5_q    <= funct5_d;
            addr_q      <= addr_d;
            rs2_q       <= rs2_d;
            old_q       <= old_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            sc_fail_q   <= sc_fail_d;
        end
    end

    // Stall is combinational on the start condition but masked during reset so reset forces it low.
    assign bus.atomic_unit_stall  = (start && !reset_i) || (state_q == S_READ) || (state_q == S_WRITE);
    assign bus.atomic_unit_hazard = (state_q == S_DONE);
    assign bus.mem_req            = (state_q == S_READ) || (state_q == S_WRITE);
    assign bus.mem_we             = (state_q == S_WRITE);
    assign bus.mem_addr           = addr_q;
    assign bus.mem_wdata          = (state_q == S_WRITE) ? (q_is_sc ? rs2_q : amo_wdata) : '0;
    assign bus.amo_result         = (state_q != S_DONE) ? '0 :
                                    q_is_sc ? {{(XLEN-1){1'b0}}, sc_fail_q} : old_q;
    assign bus.reservation_valid  = res_valid_q;
endmodule

// File: tb/tb_atomic_sequencer.sv
// Bench for atomic_sequencer: transaction-level model (word memory + reservation) vs DUT, per cycle.
// Directed scenarios pin literal results; randomized ops, waits, snoops and interrupts follow.
// The bench acts as the data memory with programmable ack delay.
module tb_atomic_sequencer;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    atomic_sequencer_if #(.XLEN(32)) bus();
    atomic_sequencer #(.XLEN(32)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // Model state: word-addressed memory and the reservation.
    logic [31:0] mem_m [logic [29:0]];
    bit          m_res_v = 1'b0;
    logic [29:0] m_res_a = '0;

    // Observations of the last run_op for literal checks.
    logic [31:0] o_result;
    logic [31:0] o_wdata;
    int          o_cycles;
    int          o_reqs;

    logic [4:0] ops [11] = '{F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR, F_MIN, F_MAX, F_MINU, F_MAXU};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [29:0] w);
        if (mem_m.exists(w)) return mem_m[w];
        return 32'h0;
    endfunction

    function automatic logic [31:0] amo_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            F_ADD:   return a + b;
            F_XOR:   return a ^ b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_MIN:   return ($signed(a) < $signed(b)) ? a : b;
            F_MAX:   return ($signed(a) > $signed(b)) ? a : b;
            F_MINU:  return (a < b) ? a : b;
            F_MAXU:  return (a > b) ? a : b;
            default: return b;
        endcase
    endfunction

    task automatic quiet_inputs();
        bus.amo_valid         = 1'b0;
        bus.interrupt         = 1'b0;
        bus.store_snoop_valid = 1'b0;
        bus.mem_ack           = 1'b0;
        bus.mem_rdata         = $urandom;
    endtask

    // One idle cycle with optional snoop store and interrupt pulse.
    task automatic idle_cycle(input bit sv, input logic [31:0] sa, input bit intr);
        @(negedge clk);
        quiet_inputs();
        bus.store_snoop_valid = sv;
        bus.store_snoop_addr  = sa;
        bus.interrupt         = intr;
        #1;
        chk("idle_stall", bus.atomic_unit_stall, 0);
        chk("idle_req", bus.mem_req, 0);
        chk("idle_hazard", bus.atomic_unit_hazard, 0);
        chk("idle_resv", bus.reservation_valid, m_res_v);
        if (intr || (sv && sa[31:2] == m_res_a)) m_res_v = 1'b0;
    endtask

    // amo_valid together with an interrupt: must be ignored entirely.
    task automatic intr_start(input logic [31:0] a);
        @(negedge clk);
        quiet_inputs();
        bus.amo_valid  = 1'b1;
        bus.interrupt  = 1'b1;
        bus.amo_funct5 = ops[$urandom_range(0, 10)];
        bus.amo_addr   = a;
        bus.amo_rs2    = $urandom;
        #1;
        chk("intr_stall", bus.atomic_unit_stall, 0);
        chk("intr_req", bus.mem_req, 0);
        m_res_v = 1'b0;
    endtask

    // Issue one atomic, act as memory with rw/ww ack waits, check every cycle until DONE.
    task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] d,
                          input int rw, input int ww, input bit intr_mid, input bit rst_in_write);
        logic [29:0] word;
        bit lr, sc, hit, exp_rd, exp_wr, done, aborted;
        logic [31:0] old, exp_wd, exp_res;
        int exp_cyc, cyc, nrd, nwr;
        word    = a[31:2];
        lr      = (f == F_LR);
        sc      = (f == F_SC);
        hit     = m_res_v && (m_res_a == word);
        old     = mrd(word);
        exp_rd  = !sc;
        exp_wr  = !lr && !(sc && !hit);
        exp_wd  = sc ? d : amo_op(f, old, d);
        exp_res = sc ? (hit ? 32'h0 : 32'h1) : old;
        exp_cyc = 2 + (exp_rd ? 1 + rw : 0) + (exp_wr ? 1 + ww : 0);
        done = 1'b0; aborted = 1'b0; cyc = 0; nrd = 0; nwr = 0;
        o_reqs = 0; o_wdata = 32'h0; o_result = 32'hDEAD_BEEF;
        @(negedge clk);
        quiet_inputs();
        bus.amo_valid  = 1'b1;
        bus.amo_funct5 = f;
        bus.amo_addr   = a;
        bus.amo_rs2    = d;
        for (int c = 1; c <= 60 && !done; c++) begin
            if (c > 1) begin
                @(negedge clk);
                quiet_inputs();
                bus.amo_funct5 = $urandom;
                bus.amo_addr   = $urandom;
                bus.amo_rs2    = $urandom;
                bus.interrupt  = intr_mid && (c == 2);
            end
            #1;
            cyc = c;
            if (bus.atomic_unit_hazard) begin
                done = 1'b1;
            end else begin
                chk("stall", bus.atomic_unit_stall, 1);
                chk("req", bus.mem_req, (c > 1) ? 1 : 0);
                if (bus.mem_req) begin
                    o_reqs++;
                    chk("addr", bus.mem_addr, a);
                    chk("we", bus.mem_we, (exp_rd && nrd <= rw) ? 0 : 1);
                    if (!bus.mem_we) begin
                        nrd++;
                        if (nrd == rw + 1) begin
                            bus.mem_ack   = 1'b1;
                            bus.mem_rdata = old;
                        end
                    end else begin
                        chk("wdata", bus.mem_wdata, exp_wd);
                        o_wdata = bus.mem_wdata;
                        nwr++;
                        if (rst_in_write) begin
                            bus.amo_valid = 1'b1;
                            #1 rst = 1'b1;
                            #1;
                            chk("rst_stall", bus.atomic_unit_stall, 0);
                            chk("rst_hazard", bus.atomic_unit_hazard, 0);
                            chk("rst_req", bus.mem_req, 0);
                            chk("rst_we", bus.mem_we, 0);
                            chk("rst_addr", bus.mem_addr, 0);
                            chk("rst_wdata", bus.mem_wdata, 0);
                            chk("rst_result", bus.amo_result, 0);
                            chk("rst_resv", bus.reservation_valid, 0);
                            @(negedge clk);
                            rst = 1'b0;
                            quiet_inputs();
                            m_res_v = 1'b0;
                            aborted = 1'b1;
                            done    = 1'b1;
                        end else if (nwr == ww + 1) begin
                            bus.mem_ack = 1'b1;
                        end
                    end
                end
            end
        end
        if (!done) begin
            chk("done_timeout", 0, 1);
        end else if (!aborted) begin
            o_result = bus.amo_result;
            o_cycles = cyc;
            chk("result", bus.amo_result, exp_res);
            chk("cycles", cyc, exp_cyc);
            chk("nreq", o_reqs, exp_cyc - 2);
            chk("done_stall", bus.atomic_unit_stall, 0);
            chk("done_req", bus.mem_req, 0);
            chk("done_wdata", bus.mem_wdata, 0);
            if (exp_wr) mem_m[word] = exp_wd;
            if (lr) begin
                m_res_v = 1'b1;
                m_res_a = word;
            end else if (sc || intr_mid || hit) begin
                m_res_v = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        bus.amo_valid        = 1'b1;
        bus.amo_funct5       = F_LR;
        bus.amo_addr         = 32'h100;
        bus.amo_rs2          = 32'h0;
        bus.store_snoop_addr = 32'h0;
        #12;
        chk("reset_stall", bus.atomic_unit_stall, 0);
        chk("reset_hazard", bus.atomic_unit_hazard, 0);
        chk("reset_req", bus.mem_req, 0);
        chk("reset_result", bus.amo_result, 0);
        chk("reset_resv", bus.reservation_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet_inputs();

        // LR then successful SC, then a second SC that must fail.
        mem_m[30'h40] = 32'h5;
        run_op(F_LR, 32'h100, 32'h0, 0, 0, 0, 0);
        chk("lr_lit_result", o_result, 32'h5);
        chk("lr_lit_cycles", o_cycles, 3);
        idle_cycle(0, 32'h0, 0);
        chk("lr_lit_resv", bus.reservation_valid, 1);
        run_op(F_SC, 32'h100, 32'hAB, 0, 0, 0, 0);
        chk("sc_ok_lit_result", o_result, 32'h0);
        chk("sc_ok_lit_wdata", o_wdata, 32'hAB);
        idle_cycle(0, 32'h0, 0);
        run_op(F_SC, 32'h100, 32'hCD, 0, 0, 0, 0);
        chk("sc_fail_lit_result", o_result, 32'h1);
        chk("sc_fail_lit_reqs", o_reqs, 0);

        // Snoop store to the reserved word, then an interrupt, each kills the SC.
        run_op(F_LR, 32'h100, 32'h0, 0, 0, 0, 0);
        idle_cycle(1, 32'h102, 0);
        run_op(F_SC, 32'h100, 32'h11, 0, 0, 0, 0);
        chk("sc_snoop_lit", o_result, 32'h1);
        run_op(F_LR, 32'h100, 32'h0, 0, 0, 0, 0);
        idle_cycle(0, 32'h0, 1);
        run_op(F_SC, 32'h100, 32'h22, 0, 0, 0, 0);
        chk("sc_intr_lit", o_result, 32'h1);

        // Arithmetic corner cases.
        mem_m[30'h80] = 32'hFFFF_FFFF;
        run_op(F_ADD, 32'h200, 32'h2, 0, 0, 0, 0);
        chk("add_lit_wdata", o_wdata, 32'h1);
        chk("add_lit_result", o_result, 32'hFFFF_FFFF);
        mem_m[30'hC0] = 32'h8000_0000;
        run_op(F_MIN, 32'h300, 32'h1, 0, 0, 0, 0);
        chk("min_lit_wdata", o_wdata, 32'h8000_0000);
        run_op(F_MINU, 32'h300, 32'h1, 0, 0, 0, 0);
        chk("minu_lit_wdata", o_wdata, 32'h1);

        // Delayed acks stretch the sequence; stall over 8 cycles, hazard on the 9th.
        run_op(F_SWAP, 32'h400, 32'h77, 3, 2, 0, 0);
        chk("swap_lit_cycles", o_cycles, 9);

        // Interrupt alongside amo_valid in IDLE, then reset during WRITE.
        intr_start(32'h100);
        idle_cycle(0, 32'h0, 0);
        run_op(F_LR, 32'h500, 32'h0, 0, 0, 0, 0);
        run_op(F_ADD, 32'h200, 32'h5, 1, 3, 0, 1);
        idle_cycle(0, 32'h0, 0);

        // Randomized traffic over a few words to provoke reservation hits and clears.
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = 32'h1000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: idle_cycle(1'b1, 32'h1000 + 32'($urandom_range(0, 15)), 1'b0);
                1: idle_cycle(1'b0, 32'h0, ($urandom_range(0, 2) == 0));
                2: intr_start(a);
                default: begin
                    run_op(ops[($urandom_range(0, 2) == 0) ? 1 : $urandom_range(0, 10)], a, $urandom,
                           $urandom_range(0, 3), $urandom_range(0, 3),
                           ($urandom_range(0, 7) == 0), 1'b0);
                end
            endcase
        end
        idle_cycle(0, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/atomic_sequencer.md
# atomic_sequencer

Multi-cycle sequencer for RV32A atomics (LR.W, SC.W, AMO*.W) sitting at the MEM stage beside the data-memory port. It owns the load-reserved reservation and runs the read, modify and write steps against data memory. It drives `atomic_unit_stall` and `atomic_unit_hazard` into the pipeline controller to freeze the pipeline and insert a bubble. It returns the rd value to the MEM/WB path.

## Interface
- `XLEN`, 32: data/address width.

- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `amo_valid`  in  1  atomic instruction present in MEM stage (EXE/MEM register)
- `amo_funct5`  in  5  RV32A funct5: LR=00010, SC=00011, SWAP=00001, ADD=00000, XOR=00100, AND=01100, OR=01000, MIN=10000, MAX=10100, MINU=11000, MAXU=11100
- `amo_addr`  in  XLEN  effective address (rs1)
- `amo_rs2`  in  XLEN  rs2 operand
- `interrupt`  in  1  trap/interrupt taken this cycle
- `store_snoop_valid`  in  1  ordinary store committing to memory this cycle
- `store_snoop_addr`  in  XLEN  address of that store
- `mem_rdata`  in  XLEN  read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completes current request
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write request
- `mem_addr`  out  XLEN  request address
- `mem_wdata`  out  XLEN  write data
- `atomic_unit_stall`  out  1  freeze PC..EXE/MEM, clear MEM/WB
- `atomic_unit_hazard`  out  1  hold front end, bubble EXE/MEM, MEM/WB advances
- `amo_result`  out  XLEN  rd value, valid while `atomic_unit_hazard`=1
- `reservation_valid`  out  1  reservation set (debug)

## Operation
- States: IDLE, READ, WRITE, DONE, one-hot or 2-bit encoded.
- Registered: `old_q` (captured read data), `res_valid`, `res_addr[XLEN-1:2]`, `sc_fail_q`, and latched `funct5`, `addr` and `rs2` at start.
- IDLE, `amo_valid`=1, `interrupt`=0:
  - LR or AMO: go to READ.
  - SC with reservation hit (`res_valid` and `amo_addr[XLEN-1:2]`==`res_addr`): go to WRITE.
  - SC with miss: go to DONE with `sc_fail_q`=1.
- IDLE, `amo_valid`=1, `interrupt`=1: stay IDLE, no memory access.
- READ: `mem_req`=1, `mem_we`=0, `mem_addr`=latched addr, held until `mem_ack`.
  - On ack: `old_q`<=`mem_rdata`.
  - LR: set `res_valid`, `res_addr`; go to DONE.
  - AMO: go to WRITE.
- WRITE: `mem_req`=1, `mem_we`=1, held until `mem_ack`, then go to DONE.
  - AMO: `mem_wdata` = op(`old_q`, rs2). SWAP=rs2. ADD wraps mod 2^XLEN. XOR/AND/OR bitwise. MIN/MAX signed compare, MINU/MAXU unsigned.
  - SC: `mem_wdata`=rs2.
- DONE: one cycle, then IDLE.
  - `amo_result`: old value (AMO), loaded value (LR), 0 (SC success), 1 (SC fail).
  - Any SC, success or fail, clears `res_valid`.
- Reservation also cleared by:
  - `interrupt`=1, any state.
  - `store_snoop_valid` with word-address match.
  - A successful AMO to the reserved word.
  - Clear wins over a same-cycle LR set, except an LR completing in READ on the same cycle: the LR set wins.
- `interrupt` in READ/WRITE does not abort the bus access. The sequence completes; only the reservation is cleared.
- Outputs when not in READ/WRITE: `mem_req`=0, `mem_we`=0, `mem_wdata`=0, `mem_addr`=latched addr.

## Timing
- `atomic_unit_stall` = (IDLE & `amo_valid` & ~`interrupt`) | READ | WRITE. It is combinational, so the pipeline freezes in the start cycle.
- `atomic_unit_hazard` = DONE. The atomic retires into MEM/WB, EXE/MEM takes a bubble, and the EXE instruction is held one extra cycle.
- `mem_req` is asserted from state only, never in IDLE. An ack in the same cycle as req is legal.
- Minimum latencies, start cycle to DONE inclusive, with zero-wait ack:
  - LR: 3 cycles.
  - SC fail: 2 cycles.
  - SC success: 3 cycles.
  - AMO: 4 cycles.
- Each wait cycle on `mem_ack` adds one cycle.
- Reset, asynchronous at any point including mid-transaction:
  - State=IDLE; `res_valid`, `old_q`, `sc_fail_q` = 0.
  - All outputs 0, including `atomic_unit_stall`=0.
  - A dropped in-flight request is the memory side's concern.
- `amo_valid` is ignored outside IDLE; the inputs were latched at start.

## Test plan
- LR to 0x100 with mem=0x5, ack zero-wait → READ 1 cycle, DONE with `amo_result`=0x5, `reservation_valid`=1, stall high for 2 cycles, hazard for 1.
- LR 0x100 then SC 0x100 rs2=0xAB → write 0xAB to 0x100, `amo_result`=0. A second SC then fails with `amo_result`=1 and no `mem_req`.
- LR 0x100, snoop store to 0x102, then SC 0x100 → fail (1), no write. Repeat with an `interrupt` pulse instead of the snoop → fail.
- AMOADD 0x200, mem=0xFFFFFFFF, rs2=2 → write 0x1, result 0xFFFFFFFF.
- AMOMIN mem=0x80000000, rs2=1 → write 0x80000000.
- AMOMINU with the same operands → write 0x1.
- AMOSWAP with `mem_ack` delayed 3 cycles in READ and 2 in WRITE → `mem_req` held steady, stall high for 1+4+3=8 cycles, hazard on cycle 9.
- Assert `reset` during WRITE → all outputs 0 immediately, state IDLE, `reservation_valid`=0.
- `amo_valid` with `interrupt` in IDLE → no stall, no request.
